// File: rtl/avalon_src_ctrl.sv
// Avalon-ST source controller: gates an upstream stream into runs of fixed-length
// frames with idle gaps, forwarding each accepted beat one cycle later with framing checks.
module avalon_src_ctrl #(
    parameter int unsigned LEN0 = 128,
    parameter int unsigned LEN1 = 256,
    parameter int unsigned LEN2 = 512
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_start,
    input  logic [7:0] I_mod,
    input  logic [7:0] I_frm_num,
    input  logic [3:0] I_gap,
    input  logic       I_sink_rdy,
    output logic       O_src_rdy,
    input  logic       I_src_sop,
    input  logic       I_src_eop,
    input  logic       I_src_val,
    input  logic [7:0] I_src_dat,
    output logic       O_sink_sop,
    output logic       O_sink_eop,
    output logic       O_sink_val,
    output logic [7:0] O_sink_dat,
    output logic       O_busy,
    output logic       O_done,
    output logic [7:0] O_frm_cnt,
    output logic       O_err_sop,
    output logic       O_err_len
);

    localparam logic [9:0] LAST0 = 10'(LEN0 - 1);
    localparam logic [9:0] LAST1 = 10'(LEN1 - 1);
    localparam logic [9:0] LAST2 = 10'(LEN2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mod_q;
    logic [7:0] frm_num_q;
    logic [3:0] gap_q;
    logic [3:0] gap_cnt;
    logic [9:0] beat_cnt;
    logic [9:0] last_idx;
    logic [7:0] frm_cnt_inc;
    logic       accept;
    logic       at_last;
    logic       frm_end;
    logic       err_sop_c;
    logic       err_len_c;

    always_comb begin
        if (mod_q == 8'd0)      last_idx = LAST0;
        else if (mod_q == 8'd1) last_idx = LAST1;
        else                    last_idx = LAST2;
    end

    // Ready is purely combinational so upstream sees zero ready latency.
    assign O_src_rdy   = (state == RUN) && I_sink_rdy;
    assign accept      = O_src_rdy && I_src_val;
    assign at_last     = (beat_cnt == last_idx);
    assign frm_end     = accept && (I_src_eop || at_last);
    assign err_sop_c   = accept && ((beat_cnt == '0) ? !I_src_sop : I_src_sop);
    assign err_len_c   = accept && (I_src_eop != at_last);
    assign frm_cnt_inc = O_frm_cnt + 8'd1;
    assign O_busy      = (state != IDLE);
    assign O_done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (I_start) state_nxt = (I_frm_num == '0) ? DONE : RUN;
            end
            RUN: begin
                if (frm_end) begin
                    if (frm_cnt_inc == frm_num_q) state_nxt = DONE;
                    else if (gap_q != '0)         state_nxt = GAP;
                    else                          state_nxt = RUN;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd1) state_nxt = RUN;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            mod_q     <= '0;
            frm_num_q <= '0;
            gap_q     <= '0;
            gap_cnt   <= '0;
            beat_cnt  <= '0;
            O_frm_cnt <= '0;
        end else begin
            if (state == IDLE && I_start) begin
                mod_q     <= I_mod;
                frm_num_q <= I_frm_num;
                gap_q     <= I_gap;
                O_frm_cnt <= '0;
                beat_cnt  <= '0;
            end else if (frm_end) begin
                O_frm_cnt <= frm_cnt_inc;
                beat_cnt  <= '0;
            end else if (accept) begin
                beat_cnt  <= beat_cnt + 10'd1;
            end

            if (state == RUN && state_nxt == GAP) gap_cnt <= gap_q;
            else if (state == GAP)                gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // A frame cut short at its final index still carries eop downstream.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_sink_val <= 1'b0;
            O_sink_sop <= 1'b0;
            O_sink_eop <= 1'b0;
            O_sink_dat <= '0;
            O_err_sop  <= 1'b0;
            O_err_len  <= 1'b0;
        end else begin
            O_sink_val <= accept;
            O_sink_sop <= accept && I_src_sop;
            O_sink_eop <= accept && (I_src_eop || at_last);
            O_sink_dat <= accept ? I_src_dat : '0;
            O_err_sop  <= err_sop_c;
            O_err_len  <= err_len_c;
        end
    end

endmodule

// File: tb/tb_avalon_src_ctrl.sv
// Self-checking bench for avalon_src_ctrl: table of frame runs plus a
// mid-frame reset sequence, with a per-cycle scoreboard of forwarded beats.
module tb_avalon_src_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] mod = '0;
    logic [7:0] frm_num = '0;
    logic [3:0] gap = '0;
    logic       sink_rdy = 1'b0;
    logic       src_rdy;
    logic       src_sop = 1'b0;
    logic       src_eop = 1'b0;
    logic       src_val = 1'b0;
    logic [7:0] src_dat = '0;
    logic       sink_sop, sink_eop, sink_val;
    logic [7:0] sink_dat;
    logic       busy, done;
    logic [7:0] frm_cnt;
    logic       err_sop, err_len;

    avalon_src_ctrl #(.LEN0(128), .LEN1(256), .LEN2(512)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_start(start), .I_mod(mod),
        .I_frm_num(frm_num), .I_gap(gap), .I_sink_rdy(sink_rdy),
        .O_src_rdy(src_rdy), .I_src_sop(src_sop), .I_src_eop(src_eop),
        .I_src_val(src_val), .I_src_dat(src_dat), .O_sink_sop(sink_sop),
        .O_sink_eop(sink_eop), .O_sink_val(sink_val), .O_sink_dat(sink_dat),
        .O_busy(busy), .O_done(done), .O_frm_cnt(frm_cnt),
        .O_err_sop(err_sop), .O_err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         val, sop, eop;
        logic [7:0] dat;
        bit         esop, elen;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        logic [7:0] mod, nfrm;
        logic [3:0] gap;
        bit         tog, rval, noise, drop_sop, miss_eop;
        int         trunc_at, sop_at;
        int         exp_cnt, exp_es, exp_el;
    } vec_t;

    obs_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int          es_seen, el_seen;

    function automatic obs_t idle_obs(input int cnt);
        obs_t o;
        o.val = 0; o.sop = 0; o.eop = 0; o.dat = '0; o.esop = 0; o.elen = 0;
        o.cnt = 8'(cnt);
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock: compare registered outputs from the last edge, drive, check state outputs, queue next expectation.
    task automatic cycle(input bit st, input bit rdy, input bit val, input bit sop, input bit eop,
                         input logic [7:0] dat, input logic [7:0] m, input logic [7:0] fn,
                         input logic [3:0] g, input bit e_rdy, input bit e_busy, input bit e_done,
                         input obs_t nxt);
        obs_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            if (err_sop) es_seen++;
            if (err_len) el_seen++;
            chk("sink_val", sink_val, e.val);
            chk("sink_sop", sink_sop, e.sop);
            chk("sink_eop", sink_eop, e.eop);
            if (e.val) chk("sink_dat", sink_dat, e.dat);
            chk("err_sop", err_sop, e.esop);
            chk("err_len", err_len, e.elen);
            chk("frm_cnt", frm_cnt, e.cnt);
        end
        start = st; sink_rdy = rdy; src_val = val; src_sop = sop; src_eop = eop;
        src_dat = dat; mod = m; frm_num = fn; gap = g;
        #1;
        chk("src_rdy", src_rdy, e_rdy);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        sb.push_back(nxt);
    endtask

    task automatic run(input vec_t v);
        int   L;
        int   cnt;
        int   beat;
        bit   tog, fend, rdy, val, sop, eop, acc, lastb, st;
        logic [7:0] dat;
        obs_t o;
        L = (v.mod == 8'd0) ? 128 : (v.mod == 8'd1) ? 256 : 512;
        cnt = 0; tog = 1; es_seen = 0; el_seen = 0;
        cycle(1, 0, 0, 0, 0, 8'h00, v.mod, v.nfrm, v.gap, 0, 0, 0, idle_obs(0));
        for (int f = 0; f < int'(v.nfrm); f++) begin
            beat = 0; fend = 0;
            while (!fend) begin
                rdy = v.tog ? tog : 1'b1;
                tog = ~tog;
                val = v.rval ? ($urandom_range(0, 3) != 0) : 1'b1;
                dat = 8'($urandom);
                sop = (beat == 0);
                if (f == 0 && v.drop_sop && beat == 0) sop = 0;
                if (f == 0 && beat == v.sop_at) sop = 1;
                lastb = (beat == L - 1);
                eop = lastb;
                if (f == 0 && beat == v.trunc_at) eop = 1;
                if (f == 0 && v.miss_eop && lastb) eop = 0;
                acc = rdy && val;
                o = idle_obs(cnt);
                if (acc) begin
                    fend = eop || lastb;
                    o.val = 1; o.sop = sop; o.eop = fend; o.dat = dat;
                    o.esop = (beat == 0) ? !sop : sop;
                    o.elen = (eop && !lastb) || (lastb && !eop);
                    if (fend) cnt++;
                    o.cnt = 8'(cnt);
                    beat++;
                end
                st = v.noise;
                cycle(st, rdy, val, sop, eop, dat,
                      st ? 8'($urandom) : v.mod, st ? 8'($urandom) : v.nfrm,
                      st ? 4'($urandom) : v.gap, rdy, 1, 0, o);
            end
            if (f < int'(v.nfrm) - 1) begin
                for (int g = 0; g < int'(v.gap); g++)
                    cycle(v.noise, 1, 1, 1, 0, 8'hA5, 8'($urandom), 8'($urandom), 4'($urandom),
                          0, 1, 0, idle_obs(cnt));
            end
        end
        cycle(v.noise, 1, 1, 1, 0, 8'h5A, 8'($urandom), 8'($urandom), 4'($urandom),
              0, 1, 1, idle_obs(cnt));
        cycle(0, 1, 1, 1, 0, 8'h3C, v.mod, v.nfrm, v.gap, 0, 0, 0, idle_obs(cnt));
        chk("final_frm_cnt", frm_cnt, 32'(v.exp_cnt));
        chk("err_sop_pulses", 32'(es_seen), 32'(v.exp_es));
        chk("err_len_pulses", 32'(el_seen), 32'(v.exp_el));
    endtask

    vec_t tbl[8];
    vec_t rv;
    obs_t o;

    initial begin
        //            mod    nfrm   gap   tog rv nz ds me trunc sop_at cnt es el
        tbl[0] = '{8'd0, 8'd2, 4'd3,  0, 0, 0, 0, 0, -1, -1, 2, 0, 0};
        tbl[1] = '{8'd1, 8'd1, 4'd0,  1, 0, 0, 0, 0, -1, -1, 1, 0, 0};
        tbl[2] = '{8'd2, 8'd2, 4'd1,  0, 0, 0, 0, 0, 99, -1, 2, 0, 1};
        tbl[3] = '{8'd7, 8'd1, 4'd0,  0, 0, 0, 1, 1, -1, -1, 1, 1, 1};
        tbl[4] = '{8'd0, 8'd1, 4'd2,  0, 0, 0, 1, 0,  0, -1, 1, 1, 1};
        tbl[5] = '{8'd0, 8'd0, 4'd5,  0, 0, 1, 0, 0, -1, -1, 0, 0, 0};
        tbl[6] = '{8'd0, 8'd3, 4'd0,  0, 1, 1, 0, 0, -1, -1, 3, 0, 0};
        tbl[7] = '{8'd1, 8'd2, 4'd15, 1, 0, 0, 0, 0, -1, 10, 2, 1, 0};

        sink_rdy = 1'b1;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_src_rdy", src_rdy, 0);
        chk("reset_sink_val", sink_val, 0);
        chk("reset_frm_cnt", frm_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(idle_obs(0));

        for (int i = 0; i < 8; i++) run(tbl[i]);

        // Reset pulled mid-frame: everything clears at once and no done appears.
        cycle(1, 0, 0, 0, 0, 8'h00, 8'd0, 8'd2, 4'd0, 0, 0, 0, idle_obs(0));
        for (int b = 0; b < 40; b++) begin
            o = idle_obs(0);
            o.val = 1; o.sop = (b == 0); o.dat = 8'(b + 1);
            cycle(0, 1, 1, b == 0, 0, 8'(b + 1), 8'd0, 8'd2, 4'd0, 1, 1, 0, o);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sink_val", sink_val, 0);
        chk("rst_src_rdy", src_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frm_cnt", frm_cnt, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_done", done, 0);
            chk("rst_hold_busy", busy, 0);
        end
        rst_n = 1'b1;
        sb.delete();
        sb.push_back(idle_obs(0));
        rv = '{8'd0, 8'd1, 4'd2, 0, 0, 0, 0, 0, -1, -1, 1, 0, 0};
        run(rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avalon_src_ctrl.md
AVALON_SRC_CTRL -- requirements
Module: avalon_src_ctrl

Interface
REQ-001 SHALL have parameter LEN0, default 128, beats per frame for mode 0.
REQ-002 SHALL have parameter LEN1, default 256, beats per frame for mode 1.
REQ-003 SHALL have parameter LEN2, default 512, beats per frame for any other mode.
REQ-004 SHALL have port I_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port I_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port I_start  input  1  start pulse for a run of frames.
REQ-007 SHALL have port I_mod  input  8  mode select, sampled at start.
REQ-008 SHALL have port I_frm_num  input  8  frames per run, sampled at start.
REQ-009 SHALL have port I_gap  input  4  idle cycles between frames, sampled at start.
REQ-010 SHALL have port I_sink_rdy  input  1  downstream ready.
REQ-011 SHALL have port O_src_rdy  output  1  ready to upstream source.
REQ-012 SHALL have ports I_src_sop, I_src_eop, I_src_val  input  1 each; I_src_dat  input  8  upstream Avalon-ST beat.
REQ-013 SHALL have ports O_sink_sop, O_sink_eop, O_sink_val  output  1 each; O_sink_dat  output  8  forwarded beat.
REQ-014 SHALL have port O_busy  output  1  run in progress.
REQ-015 SHALL have port O_done  output  1  one-cycle end-of-run pulse.
REQ-016 SHALL have port O_frm_cnt  output  8  frames completed in current/last run.
REQ-017 SHALL have ports O_err_sop, O_err_len  output  1 each  one-cycle framing error pulses.

Function
REQ-018 SHALL implement states IDLE, RUN, GAP, DONE.
REQ-019 IDLE: on I_start=1 SHALL latch mode, frame count, gap; clear O_frm_cnt and beat counter; go RUN, or DONE if I_frm_num=0.
REQ-020 I_start outside IDLE SHALL be ignored; I_mod/I_frm_num/I_gap changes during a run SHALL have no effect.
REQ-021 Frame length L SHALL be LEN0 if latched mode=0, LEN1 if 1, else LEN2; beat counter 10 bits.
REQ-022 O_src_rdy SHALL equal I_sink_rdy in RUN and 0 in all other states (combinational, zero ready latency).
REQ-023 Beat accepted SHALL mean O_src_rdy=1 and I_src_val=1 in the same cycle; only accepted beats count.
REQ-024 Each accepted beat SHALL appear on O_sink_* on the next cycle with O_sink_val=1; otherwise O_sink_val=0 and sop/eop=0.
REQ-025 First accepted beat of a frame with I_src_sop=0, or any later beat with I_src_sop=1, SHALL pulse O_err_sop next cycle; beat still forwarded and counted.
REQ-026 Accepted beat with I_src_eop=1 at beat index != L-1 SHALL pulse O_err_len; frame ends there.
REQ-027 Accepted beat index L-1 with I_src_eop=0 SHALL pulse O_err_len and end the frame; O_sink_eop SHALL be forced 1 on that forwarded beat.
REQ-028 At frame end SHALL increment O_frm_cnt, clear beat counter; if count reaches latched frame number go DONE, else GAP if gap>0, else remain RUN.
REQ-029 GAP SHALL last exactly latched-gap cycles then return RUN.
REQ-030 DONE SHALL assert O_done for one cycle then go IDLE; O_frm_cnt holds until next start.
REQ-031 O_busy SHALL be 1 in RUN, GAP and DONE, 0 in IDLE.
REQ-032 Both error conditions on one beat SHALL pulse both flags in the same cycle.

Reset
REQ-033 I_rst_n=0 SHALL immediately force IDLE and all outputs, counters and latched values to 0, including mid-frame; no O_done issued.

Verification
REQ-034 mod=0, frm_num=2, gap=3, sink_rdy=1, clean frames -> two 128-beat frames forwarded 1 cycle late, O_src_rdy low 3 cycles between, O_done once, O_frm_cnt=2.
REQ-035 mod=1, sink_rdy toggling every cycle -> exactly 256 beats per frame accepted only when ready high, no errors.
REQ-036 mod=2, eop injected at beat 99 -> O_err_len pulse, O_frm_cnt increments, next frame starts fresh.
REQ-037 first beat sop=0 -> O_err_sop single pulse; missing eop at beat 511 -> O_err_len and O_sink_eop forced 1.
REQ-038 I_rst_n pulled low mid-frame -> outputs 0 at once, no O_done; new I_start after release runs normally.
REQ-039 I_frm_num=0 -> O_done one cycle after start, O_src_rdy never high; I_start while busy ignored.
